ctrl_sequencer: RTL and testbench

Multi-cycle successor to the team's combinational control decoder. It accepts one opcode at a time from fetch over a valid/ready handshake, latches it, and steps through EXEC / MEM / WB / BUBBLE states. Control signals are driven per state: loads and stores hold memory strobes for a parametrised memory latency, and taken-or-not branches insert one bubble. It sits between instruction fetch and the datapath (ALU, register file, data memory) and replaces the single-cycle decoder in the multi-cycle core.

---
 rtl/ctrl_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: latches one opcode per valid/ready handshake and walks EXEC/MEM/WB/BUBBLE.
// Optional performance counters (instr_count, stall_count) are enabled by defining CTRL_SEQ_PERF_EN.
module ctrl_sequencer #(
    parameter int opwidth   = 3,
    parameter int mcodebits = 3,
    parameter int MemLat    = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [mcodebits-1:0] instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    output logic                 Branch,
    output logic                 MemtoReg,
    output logic                 MemWrite,
    output logic                 ALUSrc,
    output logic                 RegWrite,
    output logic                 Move,
    output logic                 MemRead,
    output logic [opwidth-1:0]   ALUOp,
    output logic                 busy,
    output logic                 retire
`ifdef CTRL_SEQ_PERF_EN
    ,
    output logic [15:0]          instr_count,
    output logic [15:0]          stall_count
`endif
);

    localparam int CW = $clog2(MemLat + 1);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_MOVE  = 3'b100;
    localparam logic [2:0] OP_RTL   = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_BEQ   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_BUBBLE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [2:0]    r_op_q;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          w_accept;
    logic          w_last_mem;
    logic          w_unused_instr;

    // Only the low three opcode bits are decoded; the rest are deliberately ignored.
    assign w_unused_instr = ^instr;
    assign w_accept       = instr_valid & instr_ready;
    assign w_last_mem     = (r_cnt == CW'(1));
    assign busy           = (r_state != S_IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_op_q  <= 3'b000;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_op_q <= instr[2:0];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_EXEC;
            end
            S_EXEC: begin
                case (r_op_q)
                    OP_LOAD, OP_STORE: begin
                        w_state_next = S_MEM;
                        w_cnt_next   = CW'(MemLat);
                    end
                    OP_BEQ:  w_state_next = S_BUBBLE;
                    default: w_state_next = w_accept ? S_EXEC : S_IDLE;
                endcase
            end
            S_MEM: begin
                if (w_last_mem) begin
                    w_cnt_next = '0;
                    if (r_op_q == OP_LOAD) w_state_next = S_WB;
                    else                   w_state_next = w_accept ? S_EXEC : S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            S_WB, S_BUBBLE: begin
                w_state_next = w_accept ? S_EXEC : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Moore output decode: depends only on state, latched opcode and the MEM counter.
    always_comb begin
        Branch      = 1'b0;
        MemtoReg    = 1'b0;
        MemWrite    = 1'b0;
        ALUSrc      = 1'b0;
        RegWrite    = 1'b0;
        Move        = 1'b0;
        MemRead     = 1'b0;
        ALUOp       = '0;
        retire      = 1'b0;
        instr_ready = 1'b0;
        case (r_state)
            S_IDLE: instr_ready = 1'b1;
            S_EXEC: begin
                case (r_op_q)
                    OP_ADD: begin
                        RegWrite = 1'b1; ALUOp = opwidth'(3'b000);
                        retire = 1'b1; instr_ready = 1'b1;
                    end
                    OP_AND: begin
                        RegWrite = 1'b1; ALUOp = opwidth'(3'b001);
                        retire = 1'b1; instr_ready = 1'b1;
                    end
                    OP_XOR: begin
                        RegWrite = 1'b1; ALUOp = opwidth'(3'b010);
                        retire = 1'b1; instr_ready = 1'b1;
                    end
                    OP_RTL: begin
                        RegWrite = 1'b1; ALUOp = opwidth'(3'b111);
                        retire = 1'b1; instr_ready = 1'b1;
                    end
                    OP_MOVE: begin
                        RegWrite = 1'b1; ALUSrc = 1'b1; Move = 1'b1;
                        ALUOp = opwidth'(3'b100);
                        retire = 1'b1; instr_ready = 1'b1;
                    end
                    OP_LOAD:  ALUOp = opwidth'(3'b101);
                    OP_STORE: ALUOp = opwidth'(3'b110);
                    default: begin
                        Branch = 1'b1; ALUSrc = 1'b1; ALUOp = opwidth'(3'b011);
                    end
                endcase
            end
            S_MEM: begin
                if (r_op_q == OP_LOAD) begin
                    MemRead = 1'b1;
                    ALUOp   = opwidth'(3'b101);
                end else begin
                    MemWrite = 1'b1;
                    ALUOp    = opwidth'(3'b110);
                    if (w_last_mem) begin
                        retire      = 1'b1;
                        instr_ready = 1'b1;
                    end
                end
            end
            S_WB: begin
                MemtoReg = 1'b1; RegWrite = 1'b1;
                retire = 1'b1; instr_ready = 1'b1;
            end
            S_BUBBLE: begin
                retire = 1'b1; instr_ready = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CTRL_SEQ_PERF_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            instr_count <= 16'h0000;
            stall_count <= 16'h0000;
        end else begin
            if (retire)                      instr_count <= instr_count + 16'h0001;
            if (instr_valid && !instr_ready) stall_count <= stall_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomized bench for ctrl_sequencer: a queue of expected per-cycle output vectors is built per accepted opcode.
// Also covers the directed scenarios (add, back-to-back ALU ops, load, store, beq+move, reset mid-MEM).
module tb_ctrl_sequencer;

    localparam int OPW    = 3;
    localparam int MCB    = 5;
    localparam int MEMLAT = 3;

    logic           Clk = 1'b0;
    logic           Reset;
    logic [MCB-1:0] instr;
    logic           instr_valid;
    logic           instr_ready;
    logic           Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Move, MemRead;
    logic [OPW-1:0] ALUOp;
    logic           busy;
    logic           retire;
`ifdef CTRL_SEQ_PERF_EN
    logic [15:0]    instr_count;
    logic [15:0]    stall_count;
`endif

    ctrl_sequencer #(.opwidth(OPW), .mcodebits(MCB), .MemLat(MEMLAT)) dut (
        .Clk(Clk), .Reset(Reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .Branch(Branch), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .Move(Move),
        .MemRead(MemRead), .ALUOp(ALUOp), .busy(busy), .retire(retire)
`ifdef CTRL_SEQ_PERF_EN
        , .instr_count(instr_count), .stall_count(stall_count)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       br, mtr, mw, as_, rw, mv, mr;
        logic [2:0] alu;
        logic       busy, ret, rdy;
    } exp_t;

    exp_t q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   cyc          = 0;
    logic [15:0] m_icnt = 16'h0;
    logic [15:0] m_scnt = 16'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic exp_t mk(input bit br, mtr, mw, as_, rw, mv, mr,
                                input logic [2:0] alu, input bit ret, rdy);
        exp_t e;
        e.br = br; e.mtr = mtr; e.mw = mw; e.as_ = as_; e.rw = rw; e.mv = mv; e.mr = mr;
        e.alu = alu; e.busy = 1'b1; e.ret = ret; e.rdy = rdy;
        return e;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e = '0;
        e.rdy = 1'b1;
        return e;
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, starting with its EXEC cycle.
    task automatic push_seq(input logic [2:0] op);
        case (op)
            3'b000: q.push_back(mk(0,0,0,0,1,0,0,3'b000,1,1));
            3'b001: q.push_back(mk(0,0,0,0,1,0,0,3'b001,1,1));
            3'b110: q.push_back(mk(0,0,0,0,1,0,0,3'b010,1,1));
            3'b101: q.push_back(mk(0,0,0,0,1,0,0,3'b111,1,1));
            3'b100: q.push_back(mk(0,0,0,1,1,1,0,3'b100,1,1));
            3'b010: begin
                q.push_back(mk(0,0,0,0,0,0,0,3'b101,0,0));
                for (int i = 0; i < MEMLAT; i++) q.push_back(mk(0,0,0,0,0,0,1,3'b101,0,0));
                q.push_back(mk(0,1,0,0,1,0,0,3'b000,1,1));
            end
            3'b011: begin
                q.push_back(mk(0,0,0,0,0,0,0,3'b110,0,0));
                for (int i = 0; i < MEMLAT; i++) begin
                    q.push_back(mk(0,0,1,0,0,0,0,3'b110, i == MEMLAT-1, i == MEMLAT-1));
                end
            end
            default: begin
                q.push_back(mk(1,0,0,1,0,0,0,3'b011,0,0));
                q.push_back(mk(0,0,0,0,0,0,0,3'b000,1,1));
            end
        endcase
    endtask

    // Called at a falling edge: check current outputs, drive inputs, advance the model past the next rising edge.
    task automatic step(input bit rst, input bit vld, input logic [MCB-1:0] op);
        exp_t e;
        exp_t got;
        e = (q.size() != 0) ? q[0] : idle_exp();
        got = {Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Move, MemRead,
               ALUOp, busy, retire, instr_ready};
        chk("ctrl", 32'(got), 32'(e));
`ifdef CTRL_SEQ_PERF_EN
        chk("instr_count", 32'(instr_count), 32'(m_icnt));
        chk("stall_count", 32'(stall_count), 32'(m_scnt));
`endif
        Reset = rst; instr_valid = vld; instr = op;
        @(posedge Clk);
        #1;
        if (rst) begin
            q.delete();
            m_icnt = 16'h0;
            m_scnt = 16'h0;
        end else begin
            if (e.ret) m_icnt = m_icnt + 16'h1;
            if (vld && !e.rdy) m_scnt = m_scnt + 16'h1;
            if (q.size() != 0) void'(q.pop_front());
            if (vld && e.rdy) push_seq(op[2:0]);
        end
        cyc++;
        @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1; instr_valid = 1'b0; instr = '0;
        repeat (2) @(posedge Clk);
        #1;
        @(negedge Clk);

        // add with valid for one cycle, then idle
        step(1, 0, 5'b00000);
        step(0, 1, 5'b00000);
        step(0, 0, 5'b00000);
        step(0, 0, 5'b00000);
        // xor then and back-to-back
        step(0, 1, 5'b00110);
        step(0, 1, 5'b01001);
        step(0, 0, 5'b00000);
        step(0, 0, 5'b00000);
        // load with valid held (stalls during EXEC and MEM)
        step(0, 1, 5'b00010);
        for (int i = 0; i < MEMLAT + 2; i++) step(0, 1, 5'b10000);
        step(0, 0, 5'b00000);
        // store
        step(0, 1, 5'b11011);
        for (int i = 0; i < MEMLAT + 1; i++) step(0, 0, 5'b00000);
        step(0, 0, 5'b00000);
        // beq then move
        step(0, 1, 5'b00111);
        step(0, 0, 5'b00000);
        step(0, 1, 5'b10100);
        step(0, 0, 5'b00000);
        step(0, 0, 5'b00000);
        // reset during second MEM cycle of a load
        step(1, 0, 5'b00000);
        step(0, 1, 5'b00010);
        step(0, 0, 5'b00000);
        step(0, 0, 5'b00000);
        step(1, 0, 5'b00000);
        for (int i = 0; i < 4; i++) step(0, 0, 5'b00000);

        // random traffic, including every opcode and random upper bits
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70, MCB'($urandom));
        end
        step(0, 0, 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
